fc_bias_relu_ser: RTL
=====================

Name: fc_bias_relu_ser

Overview:
- Downstream stage of the combinational fully-connected matrix-vector product.
- Captures one J-element vector of L-bit signed dot products plus a per-row bias.
- Per element: adds the bias, applies ReLU, requantizes to N-bit signed by an arithmetic right shift with saturation.
- Emits the elements serially, one per handshake, as the N-bit activation stream for the next layer.

Parameters:
- N, 8, activation bit-width; width of each output element.
- J, 3, number of rows (output vector length).
- K, 3, dot-product dimension; used only to derive L.
- L, 2*N+K-1, width of each input dot product and each bias.
- SHIFT, N-1, fixed-point right-shift amount applied after bias and ReLU.
- IW, (J>1)?$clog2(J):1, width of the element index.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, wx_in/bias_in hold a valid vector.
- in_ready, output, 1, block can accept a vector.
- wx_in, input, J*L, signed dot products; row r at [(r+1)*L-1 -: L].
- bias_in, input, J*L, signed biases; row r at [(r+1)*L-1 -: L].
- out_valid, output, 1, out_* fields valid.
- out_ready, input, 1, downstream accepts the current element.
- out_data, output, N, signed requantized activation.
- out_idx, output, IW, row index of out_data.
- out_last, output, 1, out_data is row J-1.
- out_sat, output, 1, the current element was clipped to the positive maximum.

Behaviour:
- Reset (asynchronous, any time, including mid-vector):
  - state=IDLE; out_valid, out_data, out_idx, out_last, out_sat all 0.
  - The pending vector is discarded. in_ready=1 from the first edge after rst deasserts.
- FSM states are IDLE and EMIT. in_ready = (state==IDLE), driven combinationally from state only.
- IDLE:
  - If in_valid, at the edge: capture wx_in and bias_in into internal registers; load the output registers with element 0 (out_idx=0, out_last=(J==1)); set out_valid=1; go to EMIT.
  - Otherwise hold all outputs.
- EMIT:
  - Output registers are held stable while out_valid && !out_ready.
  - On out_valid && out_ready with out_last=0: load element idx+1 from the captured registers.
  - On out_valid && out_ready with out_last=1: out_valid=0, go to IDLE.
  - in_valid is ignored in EMIT; the upstream must hold its data because in_ready=0.
- Timing:
  - First element is visible 1 cycle after the accept edge.
  - With out_ready held high, J elements appear on J consecutive cycles.
  - The next accept can occur on the cycle after the last handshake, giving a peak throughput of one vector per J+1 cycles.
- Element arithmetic, for row r:
  - s = sext(wx[r]) + sext(bias[r]), computed in L+1 bits, so there is no wrap.
  - ReLU: if s<0 then s=0.
  - q = s >>> SHIFT.
  - If q > 2^(N-1)-1: out_data = 2^(N-1)-1 and out_sat=1. Otherwise out_data = q[N-1:0] and out_sat=0.
  - out_data is therefore always within 0..2^(N-1)-1; out_sat is never 1 when s<=0.
- Index: out_idx counts 0..J-1 and never wraps within a vector; it is reset to 0 on each accept.
- Simultaneous events:
  - The final handshake and in_valid in the same cycle: in_valid is not accepted that cycle.
  - in_valid may drop or change while in_ready=0 without effect.
- X-safety: out_data, out_idx, out_last and out_sat hold their last values when out_valid=0.

Test Plan (N=8, J=3, K=3, L=18, SHIFT=7):
- Basic vector:
  - Stimulus: wx={1280,-500,20000}, bias={0,100,0}, out_ready=1.
  - Required: cycles +1..+3 give (10,idx0,sat0), (0,idx1,sat0), (127,idx2,last1,sat1); in_ready=1 again at +4.
- Backpressure:
  - Stimulus: same vector; out_ready low for 3 cycles after the first out_valid, then toggling 1/0.
  - Required: outputs stable while stalled; exactly 3 handshakes with idx 0,1,2 in order; no element lost or duplicated.
- Width extremes:
  - Stimulus: wx row0=131071, bias row0=131071; wx row1=-131072, bias row1=-131072.
  - Required: row0=127 with sat=1 (s=262142, q=2047); row1=0 with sat=0.
- Busy-ignore:
  - Stimulus: assert in_valid with a second vector during EMIT.
  - Required: in_ready=0 during EMIT; the second vector is accepted only once back in IDLE, and its elements follow the first vector's.
- Reset mid-operation:
  - Stimulus: pulse rst asynchronously (between edges) after the 2nd handshake.
  - Required: out_valid drops immediately; idx2 is never emitted; in_ready=1 after rst deasserts; the next vector starts at idx0.
- Rounding boundary:
  - Stimulus: wx={127,128,16383}, bias=0.
  - Required: {0,1,127}, all with sat=0 (16383>>7=127 is exactly the maximum, not saturated).

Source files
------------

// File: rtl/fc_bias_relu_ser_if.sv
// ----------------------------------------------------------------------------
// fc_bias_relu_ser_if : vector-in / serial-activation-out handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fc_bias_relu_ser_if #(
  parameter int N  = 8,
  parameter int J  = 3,
  parameter int K  = 3,
  parameter int L  = 2*N+K-1,
  parameter int IW = (J > 1) ? $clog2(J) : 1
);
  logic             in_valid;
  logic             in_ready;
  logic [J*L-1:0]   wx_in;
  logic [J*L-1:0]   bias_in;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             out_sat;

  modport master (
    output in_valid, wx_in, bias_in, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, out_sat
  );

  modport slave (
    input  in_valid, wx_in, bias_in, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/fc_bias_relu_ser.sv
// ----------------------------------------------------------------------------
// fc_bias_relu_ser : bias add, ReLU, shift/saturate requantize, serial output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fc_bias_relu_ser #(
  parameter int N     = 8,
  parameter int J     = 3,
  parameter int K     = 3,
  parameter int L     = 2*N+K-1,
  parameter int SHIFT = N-1,
  parameter int IW    = (J > 1) ? $clog2(J) : 1
) (
  input  logic                clk,
  input  logic                rst,
  fc_bias_relu_ser_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic signed [L:0] c_QMAX     = (L+1)'((1 << (N-1)) - 1);
  localparam logic [IW-1:0]     c_LAST_IDX = IW'(J-1);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [J*L-1:0]      r_wx;
  logic [J*L-1:0]      r_bias;
  logic                w_capture;

  logic                r_valid;
  logic [N-1:0]        r_data;
  logic [IW-1:0]       r_idx;
  logic                r_last;
  logic                r_sat;

  logic                w_valid_nxt;
  logic [N-1:0]        w_data_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_last_nxt;
  logic                w_sat_nxt;

  logic [IW-1:0]       w_next_idx;
  logic [L-1:0]        w_sel_wx;
  logic [L-1:0]        w_sel_bias;
  logic signed [L:0]   w_sum;
  logic signed [L:0]   w_relu;
  logic signed [L:0]   w_q;
  logic [N-1:0]        w_elem_data;
  logic                w_elem_sat;

  assign w_next_idx = r_idx + IW'(1);

  // Element 0 comes straight from the input bus on accept; later elements
  // come from the captured copy, selected by the upcoming index.
  always_comb begin
    w_sel_wx   = bus.wx_in[L-1:0];
    w_sel_bias = bus.bias_in[L-1:0];
    if (r_state == EMIT) begin
      for (int r = 0; r < J; r++) begin
        if (w_next_idx == IW'(r)) begin
          w_sel_wx   = r_wx[r*L +: L];
          w_sel_bias = r_bias[r*L +: L];
        end
      end
    end
  end

  // One extra bit of headroom keeps the bias add from wrapping.
  assign w_sum       = $signed({w_sel_wx[L-1], w_sel_wx}) + $signed({w_sel_bias[L-1], w_sel_bias});
  assign w_relu      = w_sum[L] ? '0 : w_sum;
  assign w_q         = w_relu >>> SHIFT;
  assign w_elem_sat  = (w_q > c_QMAX);
  assign w_elem_data = w_elem_sat ? c_QMAX[N-1:0] : w_q[N-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_sat_nxt   = r_sat;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_elem_data;
          w_sat_nxt   = w_elem_sat;
          w_idx_nxt   = '0;
          w_last_nxt  = (J == 1);
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (r_valid && bus.out_ready) begin
          if (r_last) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_data_nxt  = w_elem_data;
            w_sat_nxt   = w_elem_sat;
            w_idx_nxt   = w_next_idx;
            w_last_nxt  = (w_next_idx == c_LAST_IDX);
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wx   <= '0;
      r_bias <= '0;
    end else if (w_capture) begin
      r_wx   <= bus.wx_in;
      r_bias <= bus.bias_in;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = r_last;
  assign bus.out_sat   = r_sat;

endmodule

`default_nettype wire
